// File: rtl/keypad_scan_rx.sv
// 4x4 matrix keypad scanner: column drive, row sync, debounce, hex decode, 4-digit entry register.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_scan_rx #(
  parameter int SCAN_DIV     = 100000,
  parameter int DEBOUNCE     = 4,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [15:0] entry
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int DB_W   = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_DB,
    S_PRESSED,
    S_RELEASE_DB
  } state_t;

  function automatic logic [3:0] key_map(input logic [1:0] c, input logic [1:0] r);
    logic [3:0] code;
    case ({c, r})
      4'h0: code = 4'h1;
      4'h1: code = 4'h4;
      4'h2: code = 4'h7;
      4'h3: code = 4'h0;
      4'h4: code = 4'h2;
      4'h5: code = 4'h5;
      4'h6: code = 4'h8;
      4'h7: code = 4'hF;
      4'h8: code = 4'h3;
      4'h9: code = 4'h6;
      4'hA: code = 4'h9;
      4'hB: code = 4'hE;
      4'hC: code = 4'hA;
      4'hD: code = 4'hB;
      4'hE: code = 4'hC;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  logic [3:0]        row_meta_q, row_sync_q;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        col_q;
  logic              sample, scan_end;

  logic [2:0]        col_low_cnt;
  logic              col_hit;
  logic [3:0]        col_code;
  logic [1:0]        acc_cnt_q;
  logic              acc_hit_q;
  logic [3:0]        acc_code_q;
  logic [2:0]        sum_cnt;
  logic              scan_pressed;
  logic [3:0]        scan_code;

  state_t            state_q;
  logic [3:0]        cand_q;
  logic [DB_W-1:0]   db_cnt_q, db_inc;
  logic              db_reach, match;
  logic [3:0]        key_code_q;
  logic              key_valid_q, key_held_q;
  logic [15:0]       entry_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
    end else begin
      row_meta_q <= row;
      row_sync_q <= row_meta_q;
    end
  end

  assign sample   = (slot_q == SLOT_W'(SCAN_DIV - 1));
  assign scan_end = sample && (idx_q == 2'd3);

  always_comb begin
    slot_d = slot_q + SLOT_W'(1);
    idx_d  = idx_q;
    if (sample) begin
      slot_d = '0;
      idx_d  = idx_q + 2'd1;
    end
  end

  // Column drive is registered so the decoder cannot glitch onto the keypad.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
      idx_q  <= 2'd0;
      col_q  <= 4'b1110;
    end else begin
      slot_q <= slot_d;
      idx_q  <= idx_d;
      if (sample) col_q <= ~(4'b0001 << idx_d);
    end
  end

  assign col = col_q;

  // Walk rows high to low so the lowest low row leaves its code behind.
  always_comb begin
    col_low_cnt = 3'd0;
    col_hit     = 1'b0;
    col_code    = 4'h0;
    for (int r = 3; r >= 0; r--) begin
      if (!row_sync_q[r]) begin
        col_low_cnt = col_low_cnt + 3'd1;
        col_hit     = 1'b1;
        col_code    = key_map(idx_q, 2'(r));
      end
    end
  end

  assign sum_cnt      = {1'b0, acc_cnt_q} + col_low_cnt;
  assign scan_pressed = (sum_cnt == 3'd1);
  assign scan_code    = acc_hit_q ? acc_code_q : col_code;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt_q  <= 2'd0;
      acc_hit_q  <= 1'b0;
      acc_code_q <= 4'h0;
    end else if (scan_end) begin
      acc_cnt_q  <= 2'd0;
      acc_hit_q  <= 1'b0;
      acc_code_q <= 4'h0;
    end else if (sample) begin
      acc_cnt_q <= (sum_cnt >= 3'd2) ? 2'd2 : sum_cnt[1:0];
      if (!acc_hit_q && col_hit) begin
        acc_hit_q  <= 1'b1;
        acc_code_q <= col_code;
      end
    end
  end

  assign match    = scan_pressed && (scan_code == cand_q);
  assign db_reach = (db_cnt_q == DB_W'(DEBOUNCE - 1));
  assign db_inc   = (db_cnt_q == DB_W'(DEBOUNCE)) ? db_cnt_q : db_cnt_q + DB_W'(1);

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_W      = $clog2(REPEAT_DELAY + 1);
  localparam int REP_RELOAD = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY - REPEAT_RATE : 0;
  logic [REP_W-1:0] rep_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cand_q      <= 4'h0;
      db_cnt_q    <= '0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      entry_q     <= 16'h0000;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      key_valid_q <= 1'b0;
      if (scan_end) begin
        case (state_q)
          S_IDLE: begin
            if (scan_pressed) begin
              state_q  <= S_PRESS_DB;
              cand_q   <= scan_code;
              db_cnt_q <= DB_W'(1);
            end
          end
          S_PRESS_DB: begin
            if (match) begin
              db_cnt_q <= db_inc;
              if (db_reach) begin
                state_q     <= S_PRESSED;
                key_code_q  <= cand_q;
                key_valid_q <= 1'b1;
                entry_q     <= {entry_q[11:0], cand_q};
                key_held_q  <= 1'b1;
              end
            end else begin
              state_q <= S_IDLE;
            end
          end
          S_PRESSED: begin
            if (!match) begin
              state_q  <= S_RELEASE_DB;
              db_cnt_q <= DB_W'(1);
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_q    <= '0;
            end else if (rep_q == REP_W'(REPEAT_DELAY - 1)) begin
              // Reload rather than clear so later repeats use the shorter rate.
              rep_q       <= REP_W'(REP_RELOAD);
              key_valid_q <= 1'b1;
              entry_q     <= {entry_q[11:0], cand_q};
            end else begin
              rep_q <= rep_q + REP_W'(1);
`endif
            end
          end
          default: begin
            if (match) begin
              state_q <= S_PRESSED;
            end else begin
              db_cnt_q <= db_inc;
              if (db_reach) begin
                state_q    <= S_IDLE;
                key_held_q <= 1'b0;
              end
            end
          end
        endcase
      end
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign entry     = entry_q;

endmodule

// File: doc/keypad_scan_rx.md
Name: keypad_scan_rx

Overview:
- Input-side counterpart to the 7-segment anode multiplexer: drives a 4x4 matrix keypad (Pmod KYPD on a Nexys4 Pmod header) one column at a time and reads the rows back.
- Synchronizes and debounces the row inputs, then decodes a single pressed key to a 4-bit hex code.
- Shifts each accepted key into a 16-bit entry register sized to feed the display multiplexer's data input directly.

Parameters:
- SCAN_DIV, 100000: clk cycles per column slot (1 ms at 100 MHz). Minimum 4.
- DEBOUNCE, 4: consecutive identical full scans required to accept a press or a release. Minimum 2.
- REPEAT_DELAY, 50: full scans a key must be held before the first auto-repeat. Used only with the optional feature.
- REPEAT_RATE, 10: full scans between auto-repeats. Used only with the optional feature.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; synchronous, active-high
- row  input  4  keypad rows; active-low, externally pulled up; asynchronous to clk
- col  output 4  keypad column drive; active-low, exactly one bit low at all times
- key_code  output 4  hex code of the last accepted key
- key_valid  output 1  one-cycle pulse when a key is accepted
- key_held  output 1  high while the accepted key remains debounced-pressed
- entry  output 16  last four accepted keys; newest in [3:0]

Behaviour:
- Reset values: col=4'b1110, key_code=0, key_valid=0, key_held=0, entry=0. Slot counter, column index, synchronizer, scan result and FSM state are all cleared.
- Reset is synchronous and active-high. It takes effect mid-scan or mid-debounce with no residual state.
- row passes through a 2-FF synchronizer (reset value 4'b1111).
- Slot counter runs 0..SCAN_DIV-1, then wraps and advances the column index 0→1→2→3→0.
- col = ~(1<<index).
- The synchronized row is sampled at slot count SCAN_DIV-1, which allows settling plus synchronizer delay.
- Key map, listed as (col, row) → code:
  - col0: rows 0..3 → 1,4,7,0
  - col1: rows 0..3 → 2,5,8,F
  - col2: rows 0..3 → 3,6,9,E
  - col3: rows 0..3 → A,B,C,D
- Per-scan accumulation:
  - Count low row bits across all four columns.
  - Record the code of the first low bit found (lowest column, then lowest row).
- Scan end is the sample cycle of column 3.
- Scan result R at scan end:
  - If the count is exactly 1: R = pressed with that code.
  - If the count is 0 or 2 or more (ghosting/multi-key): R = none.
  - Accumulators then clear.
- FSM evaluates only on scan-end cycles. The counter cnt saturates.
  - IDLE: R pressed → PRESS_DB, cand=R.code, cnt=1.
  - PRESS_DB:
    - R == cand: cnt+1. When cnt+1 == DEBOUNCE → PRESSED.
    - Otherwise → IDLE.
  - PRESSED: R != cand (including none) → RELEASE_DB, cnt=1.
  - RELEASE_DB:
    - R == cand → PRESSED.
    - Otherwise cnt+1. When cnt+1 == DEBOUNCE → IDLE.
- On entry to PRESSED from PRESS_DB:
  - key_code <= cand
  - key_valid = 1 for exactly the next clk cycle
  - entry <= {entry[11:0], cand}
  - key_held <= 1
- key_held clears on the transition RELEASE_DB→IDLE.
- Acceptance latency: key_valid rises 1 cycle after the scan end of the DEBOUNCE-th consecutive matching scan.
- A different key pressed while the first is held goes through RELEASE_DB → IDLE → PRESS_DB. There is no direct key-to-key transition.
- key_code holds its value after release until the next acceptance.

Optional Feature:
- Macro: KEYPAD_AUTOREPEAT_EN.
- Defined:
  - In PRESSED, a held-scan counter increments each scan end.
  - When it reaches REPEAT_DELAY, key_valid pulses and entry shifts in cand again. The counter then reloads so that subsequent repeats occur every REPEAT_RATE scans.
  - Leaving PRESSED clears the counter.
- Undefined: a key produces exactly one key_valid per press. The counter logic is absent.

Test Plan:
- Bench parameters: SCAN_DIV=4, DEBOUNCE=3.
- Reset: rst high 2 cycles → col=1110, key_code=0, key_valid=0, key_held=0, entry=0000. Then col steps 1110→1101→1011→0111 every 4 cycles.
- Press '5' (row[1] low whenever col=1101), held 6 scans → exactly one key_valid pulse, 1 cycle after the 3rd scan end. key_code=5, entry=0005, key_held=1. key_held clears 3 scans after release.
- Bounce: '5' pressed 2 scans, released 1, pressed 2, released → no key_valid, entry unchanged.
- Keys 1,2,3,A, each pressed 4 scans then released 4 scans → four pulses, entry=123A, key_code=A.
- Keys 1 and 2 held simultaneously 6 scans → no key_valid. Then '2' alone held 3 scans → key_code=2.
- Hold '7', accept, then assert rst for 1 cycle mid-scan with '7' still held → outputs return to reset values. New key_valid with key_code=7 after 3 full scans.
- With KEYPAD_AUTOREPEAT_EN and REPEAT_DELAY=5, REPEAT_RATE=2: '9' held 12 scans → pulses at acceptance, +5 scans, then every 2 scans.
